// File: rtl/vsru_chain_arbiter.sv
// Round-robin, packet-locked arbiter sharing one vector scalar reduce unit
// between MAX_CHAINS requester chains, with a tag pipeline routing results back.
module vsru_chain_arbiter #(
  parameter int N              = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_CHAINS     = 4,
  parameter int REDUCE_LATENCY = 1,
  localparam int CHAIN_W       = $clog2(MAX_CHAINS)
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           tracing,
  input  logic [MAX_CHAINS-1:0]                          req_valid,
  input  logic [MAX_CHAINS-1:0]                          req_eof,
  input  logic [MAX_CHAINS-1:0][N-1:0][DATA_WIDTH-1:0]   req_vector,
  output logic [MAX_CHAINS-1:0]                          req_ready,
  output logic                                           vsru_valid,
  output logic                                           vsru_eof,
  output logic [CHAIN_W-1:0]                             vsru_chain,
  output logic [N-1:0][DATA_WIDTH-1:0]                   vsru_vector,
  input  logic                                           vsru_valid_out,
  input  logic [N-1:0][DATA_WIDTH-1:0]                   vsru_vector_out,
  output logic [MAX_CHAINS-1:0]                          resp_valid,
  output logic                                           resp_eof,
  output logic [N-1:0][DATA_WIDTH-1:0]                   resp_vector,
  output logic                                           err,
  output logic                                           dbg_locked,
  output logic [CHAIN_W-1:0]                             dbg_owner,
  output logic [CHAIN_W-1:0]                             dbg_ptr
);

  // Handshake: a beat moves on chain i in any cycle where req_valid[i] and
  // req_ready[i] are both high; a waiting requester keeps valid and data stable.

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t               state, state_n;
  logic [CHAIN_W-1:0]   owner, owner_n;
  logic [CHAIN_W-1:0]   ptr, ptr_n;
  logic [CHAIN_W-1:0]   grant_idx;
  logic                 found;
  logic                 xfer;

  logic [REDUCE_LATENCY-1:0]              tag_valid;
  logic [REDUCE_LATENCY-1:0]              tag_eof;
  logic [REDUCE_LATENCY-1:0][CHAIN_W-1:0] tag_chain;
  logic                                   resp_hit;

  function automatic logic [CHAIN_W-1:0] wrap_idx(input logic [CHAIN_W-1:0] base,
                                                  input int off);
    return CHAIN_W'((int'(base) + off) % MAX_CHAINS);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    if (xfer) begin
      if (req_eof[grant_idx]) begin
        state_n = ST_IDLE;
        ptr_n   = wrap_idx(grant_idx, 1);
      end else begin
        state_n = ST_LOCKED;
        owner_n = grant_idx;
      end
    end
  end

  // Grant: the locked owner is offered ready even when it has nothing to send.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (rst_n && tracing) begin
      if (state == ST_LOCKED) begin
        req_ready[owner] = 1'b1;
        grant_idx        = owner;
      end else begin
        for (int k = 0; k < MAX_CHAINS; k++) begin
          if (!found && req_valid[wrap_idx(ptr, k)]) begin
            found     = 1'b1;
            grant_idx = wrap_idx(ptr, k);
          end
        end
        req_ready[grant_idx] = found;
      end
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsru_valid  <= 1'b0;
      vsru_eof    <= 1'b0;
      vsru_chain  <= '0;
      vsru_vector <= '0;
    end else begin
      vsru_valid <= xfer;
      if (xfer) begin
        vsru_eof    <= req_eof[grant_idx];
        vsru_chain  <= grant_idx;
        vsru_vector <= req_vector[grant_idx];
      end
    end
  end

  // One tag per reduce-unit pipeline stage; the tail lines up with vsru_valid_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      tag_eof   <= '0;
      tag_chain <= '0;
    end else begin
      tag_valid[0] <= vsru_valid;
      tag_eof[0]   <= vsru_eof;
      tag_chain[0] <= vsru_chain;
      for (int i = REDUCE_LATENCY - 1; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_eof[i]   <= tag_eof[i-1];
        tag_chain[i] <= tag_chain[i-1];
      end
    end
  end

  assign resp_hit = vsru_valid_out & tag_valid[REDUCE_LATENCY-1];

  always_comb begin
    resp_valid = '0;
    if (resp_hit) resp_valid[tag_chain[REDUCE_LATENCY-1]] = 1'b1;
  end

  assign resp_eof    = tag_eof[REDUCE_LATENCY-1] & resp_hit;
  assign resp_vector = vsru_vector_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (vsru_valid_out != tag_valid[REDUCE_LATENCY-1]) begin
      err <= 1'b1;
    end
  end

  assign dbg_locked = (state == ST_LOCKED);
  assign dbg_owner  = owner;
  assign dbg_ptr    = ptr;

endmodule
